// File: rtl/seq_match_rr_arbiter_if.sv
// Bus bundle for seq_match_rr_arbiter: serial detector inputs, per-channel data words,
// the arbitrated output word with its valid/ready handshake, and the overflow flags.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface seq_match_rr_arbiter_if #(
  parameter int unsigned N = 32
);
  logic [3:0]     d_in;
  logic [4*N-1:0] bit_in;
  logic           out_ready;
  logic           clr_ovf;
  logic           out_valid;
  logic [N-1:0]   bit_out;
  logic [1:0]     out_ch;
  logic [3:0]     ovf;

  modport master (
    input  d_in,
    input  bit_in,
    input  out_ready,
    input  clr_ovf,
    output out_valid,
    output bit_out,
    output out_ch,
    output ovf
  );

  modport slave (
    output d_in,
    output bit_in,
    output out_ready,
    output clr_ovf,
    input  out_valid,
    input  bit_out,
    input  out_ch,
    input  ovf
  );
endinterface

// File: rtl/seq_match_rr_arbiter.sv
// Four-channel sequence-match load controller. Each channel detects PATTERN on its serial
// stream and parks its data word in a one-deep pending buffer; a round-robin arbiter moves
// pending words into a single output register under a valid/ready handshake.
module seq_match_rr_arbiter #(
  parameter int unsigned N       = 32,
  parameter logic [3:0]  PATTERN = 4'b1110
) (
  input logic                    clk,
  input logic                    rst,
  seq_match_rr_arbiter_if.master bus
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e       state_q;
  logic [3:0]   hist_q [4];
  logic [2:0]   fill_q [4];
  logic [N-1:0] cap_q  [4];
  logic [3:0]   pend_q;
  logic [3:0]   ovf_q;
  logic         out_valid_q;
  logic [N-1:0] bit_out_q;
  logic [1:0]   out_ch_q;
  logic [1:0]   rr_q;

  logic [3:0]   match;
  logic [3:0]   drop;
  logic         take;
  logic         gnt_any;
  logic [1:0]   gnt_idx;
  logic [3:0]   gnt_vec;

  // Output register is free when idle or when the held word is being accepted.
  assign take = (state_q == StIdle) || bus.out_ready;

  // Pattern match per channel, only once four real bits have been shifted in.
  always_comb begin
    match = '0;
    for (int i = 0; i < 4; i++) begin
      match[i] = (fill_q[i] == 3'd4) && (hist_q[i] == PATTERN);
    end
  end

  // Round-robin pick: first pending channel after the last one granted.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    for (int unsigned k = 1; k < 5; k++) begin
      if (take && !gnt_any && pend_q[2'(rr_q + 2'(k))]) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(rr_q + 2'(k));
      end
    end
    gnt_vec = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  // A match is dropped only when the buffer is still occupied and not being drained now.
  assign drop = match & pend_q & ~gnt_vec;

  // Serial history shift and saturating fill counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= {hist_q[i][2:0], bus.d_in[i]};
        if (fill_q[i] != 3'd4) begin
          fill_q[i] <= fill_q[i] + 3'd1;
        end
      end
    end
  end

  // Capture on match into the pending buffer; a grant on the same edge frees the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cap_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (match[i] && !drop[i]) begin
          cap_q[i]  <= bus.bit_in[i*N +: N];
          pend_q[i] <= 1'b1;
        end else if (gnt_vec[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow; a new drop wins over a clear on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (bus.clr_ovf ? 4'b0000 : ovf_q) | drop;
    end
  end

  // Arbiter FSM with registered output word, channel and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      bit_out_q   <= '0;
      out_ch_q    <= '0;
      rr_q        <= 2'd3;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_any) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            bit_out_q   <= cap_q[gnt_idx];
            out_ch_q    <= gnt_idx;
            rr_q        <= gnt_idx;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            if (gnt_any) begin
              bit_out_q <= cap_q[gnt_idx];
              out_ch_q  <= gnt_idx;
              rr_q      <= gnt_idx;
            end else begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_match_rr_arbiter.sv
// Self-checking bench for seq_match_rr_arbiter: directed vector table, hand-written
// multi-cycle sequences, and random traffic checked against a behavioural model.
module tb_seq_match_rr_arbiter;
  localparam int unsigned N   = 32;
  localparam logic [3:0]  PAT = 4'b1110;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_match_rr_arbiter_if #(.N(N)) bus ();

  seq_match_rr_arbiter #(.N(N), .PATTERN(PAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  // Behavioural model: recent bits per channel, one parked word per channel, one output slot.
  bit           m_hist [4][$];
  bit           m_has  [4];
  logic [N-1:0] m_word [4];
  logic [3:0]   m_ovf;
  logic         m_valid;
  logic [N-1:0] m_out_word;
  logic [1:0]   m_out_ch;
  int           m_last;

  typedef struct {
    logic [1:0]   ch;
    logic [N-1:0] word;
    int           cyc;
  } acc_t;
  acc_t acc_q[$];

  typedef struct {
    bit           rst_first;
    logic [3:0]   d;
    logic         rdy;
    logic         exp_valid;
    logic [1:0]   exp_ch;
    logic [N-1:0] exp_word;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hist[i].delete();
      m_has[i]  = 1'b0;
      m_word[i] = '0;
    end
    m_ovf      = '0;
    m_valid    = 1'b0;
    m_out_word = '0;
    m_out_ch   = '0;
    m_last     = 3;
  endtask

  // What the block must do at the coming clock edge, given the current inputs.
  task automatic model_step(input logic [3:0] d, input logic [4*N-1:0] bi, input logic rdy,
                            input logic clr);
    bit         hit [4];
    int         g;
    logic [3:0] set;
    logic [3:0] w;
    g   = -1;
    set = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = 1'b0;
      if (m_hist[i].size() == 4) begin
        w = {m_hist[i][0], m_hist[i][1], m_hist[i][2], m_hist[i][3]};
        hit[i] = (w == PAT);
      end
    end
    if (!m_valid || rdy) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && m_has[(m_last + k) % 4]) g = (m_last + k) % 4;
      end
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_out_word = m_word[g];
        m_out_ch   = 2'(g);
        m_last     = g;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (hit[i]) begin
        if (!m_has[i] || g == i) begin
          m_word[i] = bi[i*N +: N];
          m_has[i]  = 1'b1;
        end else begin
          set[i] = 1'b1;
        end
      end else if (g == i) begin
        m_has[i] = 1'b0;
      end
    end
    m_ovf = (clr ? 4'b0000 : m_ovf) | set;
    for (int i = 0; i < 4; i++) begin
      m_hist[i].push_back(d[i]);
      if (m_hist[i].size() > 4) void'(m_hist[i].pop_front());
    end
  endtask

  // One clock: drive inputs, advance model, clock, then compare DUT with model.
  task automatic cyc(input logic [3:0] d, input logic [4*N-1:0] bi, input logic rdy,
                     input logic clr);
    acc_t a;
    bus.d_in      = d;
    bus.bit_in    = bi;
    bus.out_ready = rdy;
    bus.clr_ovf   = clr;
    model_step(d, bi, rdy, clr);
    if (bus.out_valid === 1'b1 && rdy) begin
      a.ch   = bus.out_ch;
      a.word = bus.bit_out;
      a.cyc  = cyc_no;
      acc_q.push_back(a);
    end
    @(posedge clk);
    #1;
    cyc_no++;
    chk($sformatf("model_valid@%0d", cyc_no), N'(bus.out_valid), N'(m_valid));
    chk($sformatf("model_word@%0d", cyc_no), bus.bit_out, m_out_word);
    chk($sformatf("model_ch@%0d", cyc_no), N'(bus.out_ch), N'(m_out_ch));
    chk($sformatf("model_ovf@%0d", cyc_no), N'(bus.ovf), N'(m_ovf));
  endtask

  // Called at posedge+1; asserts reset, checks cleared outputs, releases two edges later.
  task automatic do_reset();
    bus.d_in      = '0;
    bus.bit_in    = '0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", N'(bus.out_valid), '0);
    chk("rst_word", bus.bit_out, '0);
    chk("rst_ch", N'(bus.out_ch), '0);
    chk("rst_ovf", N'(bus.ovf), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    acc_q.delete();
  endtask

  function automatic bit pbit(input int p);
    return (p % 4) != 3;
  endfunction

  // Table rows for channel 0 only; vrow is the row after which out_valid must be high.
  task automatic add_seq(input int len, input logic [15:0] dbits, input int vrow);
    vec_t v;
    for (int k = 0; k < len; k++) begin
      v.rst_first = (k == 0);
      v.d         = {3'b000, dbits[len-1-k]};
      v.rdy       = 1'b1;
      v.exp_valid = (k == vrow);
      v.exp_ch    = 2'd0;
      v.exp_word  = (vrow >= 0 && k >= vrow) ? 32'hDEAD_BEEF : 32'h0;
      tbl.push_back(v);
    end
  endtask

  logic [4*N-1:0] tbl_bi;
  logic [4*N-1:0] bi;
  logic [3:0]     d;

  initial begin
    #6;
    model_reset();

    // Directed table: single match, short stream after reset, embedded-pattern stream.
    add_seq(8, 16'b0000_0000_1110_0000, 5);
    add_seq(7, 16'b0000_0000_0110_0000, -1);
    add_seq(11, 16'b0000_0110_1111_0000, 9);
    tbl_bi = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    foreach (tbl[r]) begin
      if (tbl[r].rst_first) do_reset();
      cyc(tbl[r].d, tbl_bi, tbl[r].rdy, 1'b0);
      chk($sformatf("tbl_valid[%0d]", r), N'(bus.out_valid), N'(tbl[r].exp_valid));
      chk($sformatf("tbl_word[%0d]", r), bus.bit_out, tbl[r].exp_word);
      chk($sformatf("tbl_ch[%0d]", r), N'(bus.out_ch), N'(tbl[r].exp_ch));
    end

    // Simultaneous matches on all channels, twice back to back.
    do_reset();
    bi = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 18; k++) begin
      d = (k < 8 && pbit(k)) ? 4'b1111 : 4'b0000;
      cyc(d, bi, 1'b1, 1'b0);
    end
    chk("sim_count", N'(acc_q.size()), N'(8));
    for (int k = 0; k < 8 && k < acc_q.size(); k++) begin
      chk($sformatf("sim_ch[%0d]", k), N'(acc_q[k].ch), N'(k % 4));
      chk($sformatf("sim_word[%0d]", k), acc_q[k].word, N'(32'h1111_1111 * ((k % 4) + 1)));
      chk($sformatf("sim_gap[%0d]", k), N'(acc_q[k].cyc - acc_q[0].cyc), N'(k));
    end

    // Backpressure: ch1 matches three times, ch2 once; third ch1 word overflows.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      d = 4'b0000;
      if (k <= 12) d[1] = pbit(k - 1);
      if (k <= 4) d[2] = pbit(k - 1);
      bi = '0;
      bi[N +: N]   = (k <= 8) ? 32'h0000_000A : ((k <= 12) ? 32'h0000_000B : 32'h0000_000C);
      bi[2*N +: N] = 32'h2222_2222;
      cyc(d, bi, 1'b0, 1'b0);
    end
    chk("bp_ovf", N'(bus.ovf), N'(4'b0010));
    chk("bp_held_valid", N'(bus.out_valid), N'(1));
    chk("bp_held_word", bus.bit_out, N'(32'h0000_000A));
    chk("bp_held_ch", N'(bus.out_ch), N'(1));
    for (int k = 0; k < 6; k++) cyc(4'b0000, bi, 1'b1, 1'b0);
    chk("bp_count", N'(acc_q.size()), N'(3));
    if (acc_q.size() >= 3) begin
      chk("bp_0_ch", N'(acc_q[0].ch), N'(1));
      chk("bp_0_word", acc_q[0].word, N'(32'h0000_000A));
      chk("bp_1_ch", N'(acc_q[1].ch), N'(2));
      chk("bp_1_word", acc_q[1].word, N'(32'h2222_2222));
      chk("bp_2_ch", N'(acc_q[2].ch), N'(1));
      chk("bp_2_word", acc_q[2].word, N'(32'h0000_000B));
    end

    // Overflow on ch3 coinciding with clr_ovf, then a lone clear.
    do_reset();
    bi = {32'h3030_3030, 96'h0};
    for (int k = 1; k <= 12; k++) cyc({pbit(k - 1), 3'b000}, bi, 1'b0, 1'b0);
    chk("race_pre_ovf", N'(bus.ovf), '0);
    cyc(4'b0000, bi, 1'b0, 1'b1);
    chk("race_set_wins", N'(bus.ovf), N'(4'b1000));
    cyc(4'b0000, bi, 1'b0, 1'b1);
    chk("race_cleared", N'(bus.ovf), '0);

    // Reset while holding a word with ch1 and ch2 pending.
    do_reset();
    bi = {32'h0, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_F00D};
    for (int k = 1; k <= 9; k++) begin
      d = 4'b0000;
      if (k <= 8) d[1] = pbit(k - 1);
      if (k <= 4) d[2] = pbit(k - 1);
      cyc(d, bi, 1'b0, 1'b0);
    end
    chk("mid_valid_before", N'(bus.out_valid), N'(1));
    do_reset();
    for (int k = 0; k < 12; k++) cyc(4'b0000, bi, 1'b1, 1'b0);
    chk("mid_no_output", N'(acc_q.size()), '0);
    for (int k = 0; k < 8; k++) cyc((k < 4 && pbit(k)) ? 4'b0001 : 4'b0000, bi, 1'b1, 1'b0);
    chk("mid_fresh_count", N'(acc_q.size()), N'(1));
    if (acc_q.size() == 1) begin
      chk("mid_fresh_ch", N'(acc_q[0].ch), '0);
      chk("mid_fresh_word", acc_q[0].word, N'(32'h0BAD_F00D));
    end

    // Random traffic against the model.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int k = 0; k < 1000; k++) begin
        d  = 4'($urandom);
        bi = {$urandom, $urandom, $urandom, $urandom};
        cyc(d, bi, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_match_rr_arbiter.md
# seq_match_rr_arbiter

Four-channel sequence-match load controller. Each channel watches its own serial bit stream for a programmable 4-bit pattern (default 1110). On a match, the channel captures its 32-bit data word into a one-deep pending buffer. A round-robin arbiter then shares a single output register among the channels, with a valid/ready handshake. The block sits between the serial detector inputs and the downstream 32-bit consumer, and replaces per-channel hold registers with one scheduled output.

## Interface
- N, 32, data word width
- PATTERN, 4'b1110, detected bit sequence, oldest bit in MSB
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- d_in  input  4  serial bit per channel, sampled every clk
- bit_in  input  4*N  channel data words; channel i is bits [i*N +: N]
- out_ready  input  1  downstream accepts the word when high with out_valid
- clr_ovf  input  1  synchronous clear of all ovf bits
- out_valid  output  1  bit_out/out_ch hold a word not yet accepted
- bit_out  output  N  granted data word
- out_ch  output  2  channel index of bit_out
- ovf  output  4  sticky per-channel overflow (match dropped)

## Operation
- **Per-channel detector**
  - hist_i <= {hist_i[2:0], d_in[i]} every cycle.
  - 3-bit fill counter saturates at 4.
  - match_i = (fill_i == 4) && (hist_i == PATTERN); combinational from registers.
  - Overlapping matches are allowed.
- **Capture**
  - On an edge where match_i = 1, buf_i <= bit_in slice i and pend_i <= 1.
  - If pend_i is already 1 and channel i is not granted on that edge, the new word is dropped, buf_i is kept, and ovf_i <= 1.
  - If pend_i is 1 and channel i is granted on that same edge, the new word loads and pend_i stays 1.
- **Arbiter FSM**, states IDLE and HOLD:
  - IDLE (out_valid = 0): if any pend is set, grant the first pending channel searching from rr+1 modulo 4. On the grant, load bit_out <= buf, out_ch <= index, rr <= index, clear that pend (unless a simultaneous match reloads it), and go to HOLD. Otherwise stay in IDLE.
  - HOLD (out_valid = 1): while out_ready = 0, bit_out and out_ch are stable. When out_ready = 1, the word is accepted. If any pend is set at that edge, grant the next channel immediately (back-to-back, stay in HOLD). Otherwise go to IDLE.
- bit_out and out_ch retain their last values in IDLE; they are never cleared except by reset.
- **ovf**: set has priority over clr_ovf on the same edge.
- **Reset values**: hist = 0, fill = 0, buf = 0, pend = 0, ovf = 0, state = IDLE, out_valid = 0, bit_out = 0, out_ch = 0, rr = 3 (so channel 0 has first priority).
- Reset asserted mid-HOLD drops the in-flight and pending words with no acceptance.

## Timing
- Let edge E0 shift in the final pattern bit.
  - E1: match_i is high during E0→E1; buf captures the bit_in value present before E1; pend set.
  - E2: out_valid = 1 with that word, if the arbiter is idle.
- Latency is 2 cycles from the final pattern bit to out_valid.
- Sustained throughput is 1 word per cycle with out_ready held high.
- A channel re-matches no sooner than 4 cycles after its previous match for PATTERN = 1110, so ovf requires backpressure.

## Test plan
- **Single match**: after reset, ch0 d_in = 1,1,1,0 with bit_in0 = 0xDEADBEEF and out_ready = 1 → out_valid high for exactly one cycle, 2 cycles after the 0 bit, with bit_out = 0xDEADBEEF and out_ch = 0. No match on the other channels.
- **Simultaneous matches**: all four channels get 1110 on the same cycles, bit_in i = 0x1111_1111*(i+1), out_ready = 1 → four consecutive valid cycles with out_ch = 0,1,2,3. Repeat immediately → order 0,1,2,3 again (rr wrapped from 3).
- **Backpressure and overflow**: out_ready = 0. ch1 matches twice (1110 1110 … with bit_in1 = 0xA then 0xB), and ch2 matches once. The first ch1 match is granted and parked in HOLD; the second ch1 match fills pend1. Then:
  - ch1 matches a third time → ovf[1] = 1 and that word is dropped.
  - Release out_ready → words 0xA (ch1), then ch2, then 0xB (ch1).
- **ovf clear race**: overflow on ch3 on the same edge as clr_ovf = 1 → ovf[3] stays 1. clr_ovf alone on the next cycle → ovf = 0.
- **Pattern negatives**: stream 1,1,0,1,1,1,1,0 on ch0 → exactly one match (after the final 0). Stream 1,1,0 immediately after reset → no match, because fill is below 4.
- **Reset mid-operation**: rst low while out_valid = 1 and pend = 0110 → all outputs return to reset values. No output appears after rst is released until a fresh 4-bit pattern arrives.
